// File: rtl/mips_pkg.sv
// Shared MIPS constants: register indices and architectural reset values,
// also used by the data-memory map.
package mips_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    localparam logic [31:0] DEFAULT_GP_INIT = 32'h1000_8000;
    localparam logic [31:0] DEFAULT_SP_INIT = 32'h7FFF_EFFC;

    localparam int REG_ZERO = 0;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

    function automatic logic is_zero_reg(input logic [DEFAULT_ADDR_WIDTH-1:0] idx);
        return idx == DEFAULT_ADDR_WIDTH'(REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port: index decode, $0 forcing and,
// with REGFILE_BYPASS_EN defined, same-cycle write-to-read forwarding.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] regs_i [2**ADDR_WIDTH],
    input  logic [ADDR_WIDTH-1:0] read_register_i,
    input  logic                  reset,
    input  logic                  reg_write_i,
    input  logic [ADDR_WIDTH-1:0] write_register_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic [DATA_WIDTH-1:0] read_data_o
);

    always_comb begin
        read_data_o = regs_i[read_register_i];
`ifdef REGFILE_BYPASS_EN
        if (!reset && reg_write_i && (write_register_i == read_register_i)) begin
            read_data_o = write_data_i;
        end
`endif
        // $0 wins over everything, including a forwarded write to index 0
        if (read_register_i == '0) begin
            read_data_o = '0;
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{reset, reg_write_i, write_register_i, write_data_i};
`endif

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: one synchronous write, two combinational reads.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module mips_register_file
    import mips_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] GP_INIT    = DATA_WIDTH'(DEFAULT_GP_INIT),
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(DEFAULT_SP_INIT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_i,
    input  logic [ADDR_WIDTH-1:0] write_register_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic [ADDR_WIDTH-1:0] read_register_1_i,
    input  logic [ADDR_WIDTH-1:0] read_register_2_i,
    output logic [DATA_WIDTH-1:0] read_data_1_o,
    output logic [DATA_WIDTH-1:0] read_data_2_o
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
        if (idx == REG_GP) return GP_INIT;
        if (idx == REG_SP) return SP_INIT;
        return '0;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (reg_write_i && (write_register_i != ADDR_WIDTH'(REG_ZERO))) begin
            regs_d[write_register_i] = write_data_i;
        end
    end

    // Reset is checked here rather than in regs_d so it always beats a write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= reset_value(i);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port_1 (
        .regs_i          (regs_q),
        .read_register_i (read_register_1_i),
        .reset           (reset),
        .reg_write_i     (reg_write_i),
        .write_register_i(write_register_i),
        .write_data_i    (write_data_i),
        .read_data_o     (read_data_1_o)
    );

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port_2 (
        .regs_i          (regs_q),
        .read_register_i (read_register_2_i),
        .reset           (reset),
        .reg_write_i     (reg_write_i),
        .write_register_i(write_register_i),
        .write_data_i    (write_data_i),
        .read_data_o     (read_data_2_o)
    );

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file; honours REGFILE_BYPASS_EN when the
// same define is given to the bench build.
module tb_mips_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_i;
    logic [4:0]  write_register_i;
    logic [31:0] write_data_i;
    logic [4:0]  read_register_1_i;
    logic [4:0]  read_register_2_i;
    logic [31:0] read_data_1_o;
    logic [31:0] read_data_2_o;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [31:0] GP_RST = 32'h1000_8000;
    localparam logic [31:0] SP_RST = 32'h7FFF_EFFC;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    mips_register_file dut (
        .clk              (clk),
        .reset            (reset),
        .reg_write_i      (reg_write_i),
        .write_register_i (write_register_i),
        .write_data_i     (write_data_i),
        .read_register_1_i(read_register_1_i),
        .read_register_2_i(read_register_2_i),
        .read_data_1_o    (read_data_1_o),
        .read_data_2_o    (read_data_2_o)
    );

    task automatic push_exp(input string n, input logic [4:0] a, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.addr = a;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs from the falling edge; it takes effect at the next rising edge.
    task automatic drive(input logic rst, input logic we, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reset            = rst;
        reg_write_i      = we;
        write_register_i = a;
        write_data_i     = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 1'b0, 5'd0, 32'h0);
        idle();
        push_exp("reset_r0", 5'd0, 32'h0);
        push_exp("reset_r28", 5'd28, GP_RST);
        push_exp("reset_r29", 5'd29, SP_RST);
        push_exp("reset_r5", 5'd5, 32'h0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_register_1_i = e.addr;
            read_register_2_i = e.addr;
            #1;
            total++;
            if (read_data_1_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p1: got %h want %h", e.name, read_data_1_o, e.val);
            end
            total++;
            if (read_data_2_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p2: got %h want %h", e.name, read_data_2_o, e.val);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        drive(1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF);
        read_register_1_i = 5'd8;
        read_register_2_i = 5'd8;
        #1;
        total++;
        if (read_data_1_o !== (BYPASS ? 32'hDEAD_BEEF : 32'h0)) begin
            bad++;
            $display("[TB] FAIL same_cycle_r8 p1: got %h want %h", read_data_1_o,
                     BYPASS ? 32'hDEAD_BEEF : 32'h0);
        end
        total++;
        if (read_data_2_o !== (BYPASS ? 32'hDEAD_BEEF : 32'h0)) begin
            bad++;
            $display("[TB] FAIL same_cycle_r8 p2: got %h want %h", read_data_2_o,
                     BYPASS ? 32'hDEAD_BEEF : 32'h0);
        end
        idle();
        push_exp("write_r8", 5'd8, 32'hDEAD_BEEF);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_register_1_i = e.addr;
            read_register_2_i = e.addr;
            #1;
            total++;
            if (read_data_1_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p1: got %h want %h", e.name, read_data_1_o, e.val);
            end
            total++;
            if (read_data_2_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p2: got %h want %h", e.name, read_data_2_o, e.val);
            end
        end
    endtask

    task automatic test_zero_register();
        exp_t e;
        drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        read_register_1_i = 5'd0;
        read_register_2_i = 5'd0;
        #1;
        total++;
        if ({read_data_1_o, read_data_2_o} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL zero_same_cycle: got %h/%h want 0", read_data_1_o, read_data_2_o);
        end
        idle();
        push_exp("zero_after", 5'd0, 32'h0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_register_1_i = e.addr;
            read_register_2_i = e.addr;
            #1;
            total++;
            if (read_data_1_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p1: got %h want %h", e.name, read_data_1_o, e.val);
            end
            total++;
            if (read_data_2_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p2: got %h want %h", e.name, read_data_2_o, e.val);
            end
        end
    endtask

    task automatic test_write_disabled();
        exp_t e;
        drive(1'b0, 1'b0, 5'd9, 32'h1234_5678);
        idle();
        push_exp("disabled_r9", 5'd9, 32'h0);
        push_exp("disabled_r8_kept", 5'd8, 32'hDEAD_BEEF);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_register_1_i = e.addr;
            read_register_2_i = e.addr;
            #1;
            total++;
            if (read_data_1_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p1: got %h want %h", e.name, read_data_1_o, e.val);
            end
            total++;
            if (read_data_2_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p2: got %h want %h", e.name, read_data_2_o, e.val);
            end
        end
    endtask

    task automatic test_reset_vs_write();
        exp_t e;
        drive(1'b0, 1'b1, 5'd29, 32'hAAAA_5555);
        drive(1'b1, 1'b1, 5'd29, 32'h0000_0001);
        // During reset the pre-reset contents are still visible and nothing is forwarded
        read_register_1_i = 5'd29;
        read_register_2_i = 5'd8;
        #1;
        total++;
        if (read_data_1_o !== 32'hAAAA_5555) begin
            bad++;
            $display("[TB] FAIL during_reset_r29: got %h want %h", read_data_1_o, 32'hAAAA_5555);
        end
        total++;
        if (read_data_2_o !== 32'hDEAD_BEEF) begin
            bad++;
            $display("[TB] FAIL during_reset_r8: got %h want %h", read_data_2_o, 32'hDEAD_BEEF);
        end
        idle();
        push_exp("rst_win_r29", 5'd29, SP_RST);
        push_exp("rst_clr_r8", 5'd8, 32'h0);
        push_exp("rst_r28", 5'd28, GP_RST);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_register_1_i = e.addr;
            read_register_2_i = e.addr;
            #1;
            total++;
            if (read_data_1_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p1: got %h want %h", e.name, read_data_1_o, e.val);
            end
            total++;
            if (read_data_2_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p2: got %h want %h", e.name, read_data_2_o, e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 5'd31, 32'd1);
        drive(1'b0, 1'b1, 5'd31, 32'd2);
        drive(1'b0, 1'b1, 5'd10, 32'd3);
        idle();
        push_exp("b2b_r31", 5'd31, 32'd2);
        push_exp("b2b_r10", 5'd10, 32'd3);
        read_register_1_i = sb[0].addr;
        read_register_2_i = sb[1].addr;
        #1;
        total++;
        if (read_data_1_o !== sb[0].val) begin
            bad++;
            $display("[TB] FAIL %s p1: got %h want %h", sb[0].name, read_data_1_o, sb[0].val);
        end
        total++;
        if (read_data_2_o !== sb[1].val) begin
            bad++;
            $display("[TB] FAIL %s p2: got %h want %h", sb[1].name, read_data_2_o, sb[1].val);
        end
        sb.delete();
    endtask

    task automatic test_random();
        exp_t        e;
        logic [4:0]  a;
        logic [31:0] d;
        logic        we;
        drive(1'b1, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[28] = GP_RST;
        model[29] = SP_RST;
        for (int n = 0; n < 40; n++) begin
            a  = 5'($urandom_range(0, 31));
            d  = $urandom;
            we = ($urandom_range(0, 3) != 0);
            drive(1'b0, we, a, d);
            if (we && a != 5'd0) model[a] = d;
        end
        idle();
        for (int i = 0; i < 32; i++) push_exp($sformatf("rand_r%0d", i), 5'(i), model[i]);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            read_register_1_i = e.addr;
            read_register_2_i = e.addr;
            #1;
            total++;
            if (read_data_1_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p1: got %h want %h", e.name, read_data_1_o, e.val);
            end
            total++;
            if (read_data_2_o !== e.val) begin
                bad++;
                $display("[TB] FAIL %s p2: got %h want %h", e.name, read_data_2_o, e.val);
            end
        end
    endtask

    initial begin
        reset             = 1'b1;
        reg_write_i       = 1'b0;
        write_register_i  = 5'd0;
        write_data_i      = 32'h0;
        read_register_1_i = 5'd0;
        read_register_2_i = 5'd0;
        test_reset();
        test_write_read();
        test_zero_register();
        test_write_disabled();
        test_reset_vs_write();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
